// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline constants for the hazard scoreboard.
//   NREG_DEF : architectural register count
//   CW_DEF   : width of each in-flight write counter
//   RIDX_W   : register index width
//   COND_AL  : "always" condition code, never waits on flags
package hazard_scoreboard_pkg;
    localparam int           NREG_DEF = 16;
    localparam int           CW_DEF   = 2;
    localparam int           RIDX_W   = 4;
    localparam int           COND_W   = 4;
    localparam logic [3:0]   COND_AL  = 4'b1110;
endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode / write-back / status bundle between the pipeline and the scoreboard.
//   master : pipeline side (drives decode, flush/freeze, retire info)
//   slave  : scoreboard side (drives hazard, issue, busy, err)
interface hazard_scoreboard_if
    import hazard_scoreboard_pkg::*;
#(
    parameter int NREG = NREG_DEF
);
    logic              id_valid;
    logic [RIDX_W-1:0] src1;
    logic [RIDX_W-1:0] src2;
    logic              src2_used;
    logic              id_wb_en;
    logic [RIDX_W-1:0] id_dest;
    logic              id_s;
    logic [COND_W-1:0] id_cond;
    logic              flush;
    logic              freeze;
    logic              wb_en;
    logic [RIDX_W-1:0] wb_dest;
    logic              flags_done;
    logic              hazard;
    logic              issue;
    logic [NREG-1:0]   busy;
    logic              err;

    modport master (
        output id_valid, src1, src2, src2_used, id_wb_en, id_dest, id_s, id_cond,
               flush, freeze, wb_en, wb_dest, flags_done,
        input  hazard, issue, busy, err
    );
    modport slave (
        input  id_valid, src1, src2, src2_used, id_wb_en, id_dest, id_s, id_cond,
               flush, freeze, wb_en, wb_dest, flags_done,
        output hazard, issue, busy, err
    );
endinterface

// File: rtl/hazard_scoreboard_counter.sv
// sb_counter: CW-bit in-flight counter.
//   clk, rst_n : clock, async active-low reset
//   inc_i      : one more write issued
//   dec_i      : one write retired
//   cnt_o      : current count
//   unf_o      : retire seen with nothing in flight (combinational)
// Simultaneous inc/dec cancel. The count never wraps in either direction.
module sb_counter #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc_i,
    input  logic          dec_i,
    output logic [CW-1:0] cnt_o,
    output logic          unf_o
);
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        unf_o = 1'b0;
        if (inc_i && !dec_i) begin
            if (cnt_q != '1) cnt_d = cnt_q + CW'(1);
        end else if (dec_i && !inc_i) begin
            if (cnt_q == '0) unf_o = 1'b1;
            else             cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight register writes and flag-setting
// instructions, stalls decode on RAW / flag / counter-full hazards.
//   clk : clock
//   rst : async active-low reset
//   sb  : slave side of hazard_scoreboard_if (decode, retire, hazard/issue/busy/err)
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int CW   = CW_DEF
) (
    input  logic                clk,
    input  logic                rst,
    hazard_scoreboard_if.slave  sb
);
    localparam logic [CW-1:0] CMAX = '1;

    logic [NREG-1:0][CW-1:0] cnt;
    logic [CW-1:0]           fcnt;
    logic [NREG:0]           unf;
    logic [NREG-1:0]         inc, dec;
    logic                    wb_go, fd_go, haz_raw, issue_w;
    logic [CW-1:0]           eff1, eff2, feff;
    logic                    err_q, err_d;

    assign wb_go = sb.wb_en && !sb.freeze;
    assign fd_go = sb.flags_done && !sb.freeze;

    // A write retiring this cycle lands in the register file before the
    // read, so it no longer blocks a consumer in decode.
    assign eff1 = cnt[sb.src1] - CW'(wb_go && (sb.wb_dest == sb.src1));
    assign eff2 = cnt[sb.src2] - CW'(wb_go && (sb.wb_dest == sb.src2));
    assign feff = fcnt - CW'(fd_go);

    // Counter-full checks use the raw count so a counter can never wrap.
    assign haz_raw = sb.id_valid && !sb.flush &&
                     ((eff1 != '0) ||
                      (sb.src2_used && (eff2 != '0)) ||
                      (sb.id_wb_en && (cnt[sb.id_dest] == CMAX)) ||
                      ((sb.id_cond != COND_AL) && (feff != '0)) ||
                      (sb.id_s && (fcnt == CMAX)));

    assign issue_w   = sb.id_valid && !sb.flush && !sb.freeze && !haz_raw;
    // Outputs read 0 while reset is held.
    assign sb.hazard = rst && haz_raw;
    assign sb.issue  = rst && issue_w;

    for (genvar r = 0; r < NREG; r++) begin : g_reg
        assign inc[r]     = issue_w && sb.id_wb_en && (sb.id_dest == RIDX_W'(r));
        assign dec[r]     = wb_go && (sb.wb_dest == RIDX_W'(r));
        assign sb.busy[r] = (cnt[r] != '0);
        sb_counter #(.CW(CW)) u_cnt (
            .clk   (clk),
            .rst_n (rst),
            .inc_i (inc[r]),
            .dec_i (dec[r]),
            .cnt_o (cnt[r]),
            .unf_o (unf[r])
        );
    end

    sb_counter #(.CW(CW)) u_fcnt (
        .clk   (clk),
        .rst_n (rst),
        .inc_i (issue_w && sb.id_s),
        .dec_i (fd_go),
        .cnt_o (fcnt),
        .unf_o (unf[NREG])
    );

    assign err_d = err_q || (|unf);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_q <= 1'b0;
        else      err_q <= err_d;
    end

    assign sb.err = err_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;
    logic clk = 1'b0;
    logic rst = 1'b0;

    hazard_scoreboard_if #(.NREG(16)) dif ();

    hazard_scoreboard #(.NREG(16), .CW(2)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (dif)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic v; logic [3:0] s1; logic [3:0] s2; logic u; logic w; logic [3:0] d;
        logic s; logic [3:0] c; logic fl; logic fz; logic wb; logic [3:0] wd; logic fd;
    } stim_t;

    typedef struct {
        logic h; logic i; logic [15:0] b; logic e;
    } exp_t;

    exp_t  q[$];
    int    vectors = 0;
    int    miscompares = 0;

    function automatic stim_t st(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                                 input logic u, input logic w, input logic [3:0] d,
                                 input logic s, input logic [3:0] c, input logic fl,
                                 input logic fz, input logic wb, input logic [3:0] wd,
                                 input logic fd);
        stim_t t;
        t = '{v, s1, s2, u, w, d, s, c, fl, fz, wb, wd, fd};
        return t;
    endfunction

    function automatic exp_t ex(input logic h, input logic i, input logic [15:0] b, input logic e);
        exp_t t;
        t.h = h; t.i = i; t.b = b; t.e = e;
        return t;
    endfunction

    task automatic apply(input stim_t t);
        dif.id_valid = t.v;  dif.src1 = t.s1;   dif.src2 = t.s2;  dif.src2_used = t.u;
        dif.id_wb_en = t.w;  dif.id_dest = t.d; dif.id_s = t.s;   dif.id_cond = t.c;
        dif.flush = t.fl;    dif.freeze = t.fz; dif.wb_en = t.wb; dif.wb_dest = t.wd;
        dif.flags_done = t.fd;
    endtask

    stim_t IDLE;
    stim_t W5;

    task automatic test_reset();
        exp_t e;
        stim_t s[$];
        s.push_back(st(1, 4'd0, 4'd0, 0, 1, 4'd1, 1, 4'hE, 0, 0, 1, 4'd2, 0));
        s.push_back(st(1, 4'd0, 4'd0, 0, 0, 4'd0, 0, 4'h0, 0, 0, 0, 4'd0, 1));
        for (int k = 0; k < s.size(); k++) begin
            apply(s[k]);
            q.push_back(ex(0, 0, 16'h0, 0));
            #2;
            e = q.pop_front();
            vectors++;
            if ({dif.hazard, dif.issue, dif.busy, dif.err} !== {e.h, e.i, e.b, e.e}) begin
                miscompares++;
                $display("FAIL reset[%0d]: got h=%b i=%b busy=%h err=%b, want h=%b i=%b busy=%h err=%b",
                         k, dif.hazard, dif.issue, dif.busy, dif.err, e.h, e.i, e.b, e.e);
            end
        end
        apply(IDLE);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_raw();
        exp_t e;
        stim_t s[$];
        exp_t x[$];
        stim_t sub;
        sub = st(1, 4'd3, 4'd1, 1, 1, 4'd4, 0, 4'hE, 0, 0, 0, 4'd0, 0);
        s.push_back(st(1, 4'd1, 4'd2, 1, 1, 4'd3, 0, 4'hE, 0, 0, 0, 4'd0, 0)); x.push_back(ex(0, 1, 16'h0000, 0));
        s.push_back(sub);                                                      x.push_back(ex(1, 0, 16'h0008, 0));
        s.push_back(sub);                                                      x.push_back(ex(1, 0, 16'h0008, 0));
        sub.wb = 1; sub.wd = 4'd3;
        s.push_back(sub);                                                      x.push_back(ex(0, 1, 16'h0008, 0));
        s.push_back(st(0, 4'd0, 4'd0, 0, 0, 4'd0, 0, 4'hE, 0, 0, 1, 4'd4, 0)); x.push_back(ex(0, 0, 16'h0010, 0));
        s.push_back(IDLE);                                                     x.push_back(ex(0, 0, 16'h0000, 0));
        for (int k = 0; k < s.size(); k++) begin
            apply(s[k]);
            q.push_back(x[k]);
            #2;
            e = q.pop_front();
            vectors++;
            if ({dif.hazard, dif.issue, dif.busy, dif.err} !== {e.h, e.i, e.b, e.e}) begin
                miscompares++;
                $display("FAIL raw[%0d]: got h=%b i=%b busy=%h err=%b, want h=%b i=%b busy=%h err=%b",
                         k, dif.hazard, dif.issue, dif.busy, dif.err, e.h, e.i, e.b, e.e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_saturate();
        exp_t e;
        stim_t s[$];
        exp_t x[$];
        stim_t w5r, r5;
        w5r = W5; w5r.wb = 1; w5r.wd = 4'd5;
        r5 = IDLE; r5.wb = 1; r5.wd = 4'd5;
        s.push_back(W5);   x.push_back(ex(0, 1, 16'h0000, 0));
        s.push_back(W5);   x.push_back(ex(0, 1, 16'h0020, 0));
        s.push_back(W5);   x.push_back(ex(0, 1, 16'h0020, 0));
        s.push_back(W5);   x.push_back(ex(1, 0, 16'h0020, 0));  // cnt=3: full
        s.push_back(w5r);  x.push_back(ex(1, 0, 16'h0020, 0));  // full check uses raw count
        s.push_back(W5);   x.push_back(ex(0, 1, 16'h0020, 0));  // back to 3
        s.push_back(r5);   x.push_back(ex(0, 0, 16'h0020, 0));  // -> 2
        s.push_back(w5r);  x.push_back(ex(0, 1, 16'h0020, 0));  // inc+dec hold at 2
        s.push_back(r5);   x.push_back(ex(0, 0, 16'h0020, 0));  // -> 1
        s.push_back(r5);   x.push_back(ex(0, 0, 16'h0020, 0));  // -> 0
        s.push_back(IDLE); x.push_back(ex(0, 0, 16'h0000, 0));
        for (int k = 0; k < s.size(); k++) begin
            apply(s[k]);
            q.push_back(x[k]);
            #2;
            e = q.pop_front();
            vectors++;
            if ({dif.hazard, dif.issue, dif.busy, dif.err} !== {e.h, e.i, e.b, e.e}) begin
                miscompares++;
                $display("FAIL saturate[%0d]: got h=%b i=%b busy=%h err=%b, want h=%b i=%b busy=%h err=%b",
                         k, dif.hazard, dif.issue, dif.busy, dif.err, e.h, e.i, e.b, e.e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_flags();
        exp_t e;
        stim_t s[$];
        exp_t x[$];
        stim_t cmp, moveq, t;
        cmp   = st(1, 4'd1, 4'd2, 1, 0, 4'd0, 1, 4'hE, 0, 0, 0, 4'd0, 0);
        moveq = st(1, 4'd0, 4'd0, 0, 1, 4'd6, 0, 4'h0, 0, 0, 0, 4'd0, 0);
        s.push_back(cmp);   x.push_back(ex(0, 1, 16'h0000, 0));
        s.push_back(moveq); x.push_back(ex(1, 0, 16'h0000, 0));
        t = moveq; t.fd = 1;
        s.push_back(t);     x.push_back(ex(0, 1, 16'h0000, 0));
        t = cmp; t.wb = 1; t.wd = 4'd6;
        s.push_back(t);     x.push_back(ex(0, 1, 16'h0040, 0));
        s.push_back(st(1, 4'd1, 4'd0, 0, 1, 4'd7, 0, 4'hE, 0, 0, 0, 4'd0, 0)); x.push_back(ex(0, 1, 16'h0000, 0));
        s.push_back(st(0, 4'd0, 4'd0, 0, 0, 4'd0, 0, 4'hE, 0, 0, 1, 4'd7, 1)); x.push_back(ex(0, 0, 16'h0080, 0));
        s.push_back(IDLE);  x.push_back(ex(0, 0, 16'h0000, 0));
        for (int k = 0; k < s.size(); k++) begin
            apply(s[k]);
            q.push_back(x[k]);
            #2;
            e = q.pop_front();
            vectors++;
            if ({dif.hazard, dif.issue, dif.busy, dif.err} !== {e.h, e.i, e.b, e.e}) begin
                miscompares++;
                $display("FAIL flags[%0d]: got h=%b i=%b busy=%h err=%b, want h=%b i=%b busy=%h err=%b",
                         k, dif.hazard, dif.issue, dif.busy, dif.err, e.h, e.i, e.b, e.e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_flush();
        exp_t e;
        stim_t s[$];
        exp_t x[$];
        s.push_back(st(1, 4'd1, 4'd0, 0, 1, 4'd3, 0, 4'hE, 0, 0, 0, 4'd0, 0)); x.push_back(ex(0, 1, 16'h0000, 0));
        s.push_back(st(1, 4'd3, 4'd3, 1, 1, 4'd8, 1, 4'h0, 1, 0, 0, 4'd0, 0)); x.push_back(ex(0, 0, 16'h0008, 0));
        s.push_back(st(0, 4'd0, 4'd0, 0, 0, 4'd0, 0, 4'hE, 0, 0, 1, 4'd3, 0)); x.push_back(ex(0, 0, 16'h0008, 0));
        s.push_back(IDLE);                                                     x.push_back(ex(0, 0, 16'h0000, 0));
        for (int k = 0; k < s.size(); k++) begin
            apply(s[k]);
            q.push_back(x[k]);
            #2;
            e = q.pop_front();
            vectors++;
            if ({dif.hazard, dif.issue, dif.busy, dif.err} !== {e.h, e.i, e.b, e.e}) begin
                miscompares++;
                $display("FAIL flush[%0d]: got h=%b i=%b busy=%h err=%b, want h=%b i=%b busy=%h err=%b",
                         k, dif.hazard, dif.issue, dif.busy, dif.err, e.h, e.i, e.b, e.e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_freeze();
        exp_t e;
        stim_t s[$];
        exp_t x[$];
        s.push_back(st(1, 4'd0, 4'd0, 0, 1, 4'd2, 0, 4'hE, 0, 0, 0, 4'd0, 0)); x.push_back(ex(0, 1, 16'h0000, 0));
        s.push_back(st(1, 4'd2, 4'd0, 0, 1, 4'd9, 0, 4'hE, 0, 1, 1, 4'd2, 0)); x.push_back(ex(1, 0, 16'h0004, 0));
        s.push_back(st(1, 4'd0, 4'd0, 0, 1, 4'd9, 0, 4'hE, 0, 1, 1, 4'd2, 0)); x.push_back(ex(0, 0, 16'h0004, 0));
        s.push_back(st(0, 4'd0, 4'd0, 0, 0, 4'd0, 0, 4'hE, 0, 0, 1, 4'd2, 0)); x.push_back(ex(0, 0, 16'h0004, 0));
        s.push_back(IDLE);                                                     x.push_back(ex(0, 0, 16'h0000, 0));
        for (int k = 0; k < s.size(); k++) begin
            apply(s[k]);
            q.push_back(x[k]);
            #2;
            e = q.pop_front();
            vectors++;
            if ({dif.hazard, dif.issue, dif.busy, dif.err} !== {e.h, e.i, e.b, e.e}) begin
                miscompares++;
                $display("FAIL freeze[%0d]: got h=%b i=%b busy=%h err=%b, want h=%b i=%b busy=%h err=%b",
                         k, dif.hazard, dif.issue, dif.busy, dif.err, e.h, e.i, e.b, e.e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        stim_t s[$];
        exp_t x[$];
        stim_t w7, r7;
        w7 = st(1, 4'd0, 4'd0, 0, 1, 4'd7, 0, 4'hE, 0, 0, 0, 4'd0, 0);
        r7 = IDLE; r7.wb = 1; r7.wd = 4'd7;
        // Build up cnt[7]=2, then pull reset between edges.
        s.push_back(w7);   x.push_back(ex(0, 1, 16'h0000, 0));
        s.push_back(w7);   x.push_back(ex(0, 1, 16'h0080, 0));
        s.push_back(IDLE); x.push_back(ex(0, 0, 16'h0080, 0));
        s.push_back(r7);   x.push_back(ex(0, 0, 16'h0000, 0));  // first cycle after release
        s.push_back(IDLE); x.push_back(ex(0, 0, 16'h0000, 1));
        s.push_back(IDLE); x.push_back(ex(0, 0, 16'h0000, 1));
        s.push_back(W5);   x.push_back(ex(0, 1, 16'h0000, 1));
        for (int k = 0; k < s.size(); k++) begin
            apply(s[k]);
            q.push_back(x[k]);
            #2;
            e = q.pop_front();
            vectors++;
            if ({dif.hazard, dif.issue, dif.busy, dif.err} !== {e.h, e.i, e.b, e.e}) begin
                miscompares++;
                $display("FAIL reset_mid[%0d]: got h=%b i=%b busy=%h err=%b, want h=%b i=%b busy=%h err=%b",
                         k, dif.hazard, dif.issue, dif.busy, dif.err, e.h, e.i, e.b, e.e);
            end
            if (k == 2) begin
                rst = 1'b0;
                #1;
                q.push_back(ex(0, 0, 16'h0000, 0));
                e = q.pop_front();
                vectors++;
                if ({dif.hazard, dif.issue, dif.busy, dif.err} !== {e.h, e.i, e.b, e.e}) begin
                    miscompares++;
                    $display("FAIL reset_mid_async: got h=%b i=%b busy=%h err=%b, want h=%b i=%b busy=%h err=%b",
                             dif.hazard, dif.issue, dif.busy, dif.err, e.h, e.i, e.b, e.e);
                end
                #2;
                rst = 1'b1;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        IDLE = st(0, 4'd0, 4'd0, 0, 0, 4'd0, 0, 4'hE, 0, 0, 0, 4'd0, 0);
        W5   = st(1, 4'd0, 4'd0, 0, 1, 4'd5, 0, 4'hE, 0, 0, 0, 4'd0, 0);
        apply(IDLE);
        test_reset();
        test_raw();
        test_saturate();
        test_flags();
        test_flush();
        test_freeze();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, want finish before 100000");
        $fatal(1);
    end
endmodule
